uart_tx_scheduler: RTL and testbench

- Round-robin scheduler that shares one UART serial transmit line among NUM_REQ byte requesters.
- Accepts one byte at a time over a valid/ready handshake and serializes it as 8N1, LSB first.
- Bit timing comes from the single-cycle baud_clk strobe produced by baud_generator; this block contains no divider of its own.
- Sits between client byte sources and the TX pin.

---
 rtl/uart_tx_scheduler.sv | 153 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin scheduler sharing one UART TX line among NUM_REQ byte sources.
//   Each accepted byte is sent as 8N1, LSB first, one bit per baud_clk strobe.
//   Optional even parity bit: define UART_TX_SCHED_PARITY_EN.
//
// Ports
//   clk        system clock (posedge)
//   reset      asynchronous, active-high reset
//   baud_clk   one-clk strobe per bit period
//   req_valid  per-requester byte pending
//   req_data   byte i at [8i+7:8i]
//   req_ready  one-hot accept pulse (IDLE only)
//   serial_out UART line, idle high
//   busy       high from accept until frame completes
//   grant_id   requester owning the current or last frame
module uart_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 serial_out,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

`ifdef UART_TX_SCHED_PARITY_EN
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic                 serial_q, serial_d;
  logic                 busy_q, busy_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;

  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      cand;
  logic [31:0]          idx;
  logic [7:0]           win_data;

  // Scan from ptr+1 upward (mod NUM_REQ); first valid requester wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx  = (32'(ptr_q) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) win_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found && !reset) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    bitcnt_d = bitcnt_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (win_found) begin
`ifdef UART_TX_SCHED_PARITY_EN
          frame_d = {1'b1, ^win_data, win_data, 1'b0};
`else
          frame_d = {1'b1, win_data, 1'b0};
`endif
          grant_d  = win_id;
          ptr_d    = win_id;
          busy_d   = 1'b1;
          bitcnt_d = '0;
          state_d  = ARMED;
        end
      end
      // Start bit is launched on a strobe so it lasts a full baud period.
      ARMED: begin
        if (baud_clk) begin
          serial_d = frame_q[0];
          frame_d  = {1'b1, frame_q[FRAME_LEN-1:1]};
          bitcnt_d = 4'd1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (baud_clk) begin
          if (bitcnt_q < 4'(FRAME_LEN)) begin
            serial_d = frame_q[0];
            frame_d  = {1'b1, frame_q[FRAME_LEN-1:1]};
            bitcnt_d = bitcnt_q + 4'd1;
          end else begin
            // Stop bit has now been on the line for a full period.
            serial_d = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      bitcnt_q <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      ptr_q    <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed bit patterns and grant orders.
module tb_uart_tx_scheduler;
  localparam int N    = 4;
  localparam int ID_W = $clog2(N);
`ifdef UART_TX_SCHED_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             baud_clk;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             serial_out;
  logic             busy;
  logic [ID_W-1:0]  grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_scheduler #(.NUM_REQ(N), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .baud_clk(baud_clk),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .serial_out(serial_out), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Strobe one cycle in eight.
  initial begin
    baud_clk = 1'b0;
    forever begin
      repeat (7) @(posedge clk);
      #2 baud_clk = 1'b1;
      @(posedge clk);
      #2 baud_clk = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input int ptr, input logic [N-1:0] v);
    int id;
    for (int k = 1; k <= N; k++) begin
      id = (ptr + k) % N;
      if (v[id]) return id;
    end
    return -1;
  endfunction

  function automatic logic [FL-1:0] make_frame(input logic [7:0] d);
`ifdef UART_TX_SCHED_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  logic          m_busy;
  int            m_grant, m_ptr, m_n, m_win;
  logic [FL-1:0] m_bits;

  always_comb m_win = pick(m_ptr, req_valid);

  // m_n counts strobes since acceptance; bit m_n-1 is on the line.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0; m_grant <= 0; m_ptr <= N-1; m_n <= 0; m_bits <= '1;
    end else if (!m_busy) begin
      if (m_win >= 0) begin
        m_busy  <= 1'b1;
        m_grant <= m_win;
        m_ptr   <= m_win;
        m_n     <= 0;
        m_bits  <= make_frame(8'(req_data >> (8*m_win)));
      end
    end else if (baud_clk) begin
      if (m_n + 1 == FL + 1) m_busy <= 1'b0;
      m_n <= m_n + 1;
    end
  end

  initial begin
    logic          exp_ser;
    logic [N-1:0]  exp_rdy;
    logic [FL-1:0] sh;
    forever begin
      @(negedge clk);
      sh      = m_bits >> (m_n - 1);
      exp_ser = (m_busy && m_n >= 1 && m_n <= FL) ? sh[0] : 1'b1;
      exp_rdy = (!reset && !m_busy && m_win >= 0) ? (N'(1) << m_win) : '0;
      check("serial_out", 32'(serial_out), 32'(exp_ser));
      check("busy",       32'(busy),       32'(m_busy));
      check("grant_id",   32'(grant_id),   32'(m_grant));
      check("req_ready",  32'(req_ready),  32'(exp_rdy));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    check("idle_timeout", 32'(ok), 32'd1);
    @(posedge clk); #2;
  endtask

  task automatic run_frame(input int idx, input logic [7:0] d,
                           output logic [FL-1:0] bits, output int bstrobe);
    int s = 0;
    bit done = 1'b0;
    bits = '0;
    bstrobe = -1;
    req_data[8*idx +: 8] = d;
    req_valid = N'(1) << idx;
    @(negedge clk);
    check("accept_ready", 32'(req_ready), 32'(1) << idx);
    @(posedge clk); #2 req_valid = '0;
    @(negedge clk);
    check("ready_pulse_end", 32'(req_ready), 32'd0);
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk);
      if (baud_clk) begin
        s++;
        @(negedge clk);
        if (s <= FL) bits[s-1] = serial_out;
        if (!busy) begin bstrobe = s; done = 1'b1; end
      end
    end
    check("frame_done", 32'(done), 32'd1);
    @(posedge clk); #2;
  endtask

  // Records accepted requester indices; optionally rewrites requester 3's
  // byte right after it is accepted.
  task automatic collect(input int n, input bit mod3, output int order[8], output int got);
    bit pend_mod = 1'b0;
    got = 0;
    for (int i = 0; i < 8; i++) order[i] = -1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) begin
        check("ready_onehot", 32'($countones(req_ready)), 32'd1);
        for (int i = 0; i < N; i++) if (req_ready[i]) order[got] = i;
        if (mod3 && order[got] == 3) pend_mod = 1'b1;
        got++;
      end
      @(posedge clk); #2;
      if (pend_mod) begin req_data[31:24] = 8'hFF; pend_mod = 1'b0; end
      if (got >= n) break;
    end
    req_valid = '0;
    check("collect_count", 32'(got), 32'(n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FL-1:0] bits, exp_a5, exp_07;
    int            bs, got;
    int            order[8];
    int            s;

`ifdef UART_TX_SCHED_PARITY_EN
    exp_a5 = 11'b10101001010;
    exp_07 = 11'b11000001110;
`else
    exp_a5 = 10'b1101001010;
    exp_07 = 10'b1000001110;
`endif

    reset = 1'b1; req_valid = '0; req_data = '0;
    @(negedge clk);
    check("rst_serial", 32'(serial_out), 32'd1);
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_ready",  32'(req_ready),  32'd0);
    check("rst_grant",  32'(grant_id),   32'd0);
    @(posedge clk); #2 reset = 1'b0;

    // Idle: nothing requested.
    repeat (100) @(posedge clk);
    #2;
    check("idle_serial", 32'(serial_out), 32'd1);
    check("idle_busy",   32'(busy),       32'd0);
    check("idle_grant",  32'(grant_id),   32'd0);

    // Single frame, 0xA5 from requester 0.
    run_frame(0, 8'hA5, bits, bs);
    check("a5_bits",        32'(bits), 32'(exp_a5));
    check("a5_busy_strobe", 32'(bs),   32'(FL + 1));
    check("a5_grant",       32'(grant_id), 32'd0);

    // Fairness with all four requesters held.
    do_reset();
    req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1111;
    collect(5, 1'b0, order, got);
    check("rr_0", 32'(order[0]), 32'd0);
    check("rr_1", 32'(order[1]), 32'd1);
    check("rr_2", 32'(order[2]), 32'd2);
    check("rr_3", 32'(order[3]), 32'd3);
    check("rr_4", 32'(order[4]), 32'd0);
    wait_idle();

    // Wrap-around from pointer 2; requester 3's byte changes after accept.
    do_reset();
    run_frame(2, 8'h5A, bits, bs);
    check("p2_busy_strobe", 32'(bs), 32'(FL + 1));
    req_data[7:0]   = 8'hC3;
    req_data[31:24] = 8'h3C;
    req_valid = 4'b1001;
    collect(2, 1'b1, order, got);
    check("wrap_0", 32'(order[0]), 32'd3);
    check("wrap_1", 32'(order[1]), 32'd0);
    wait_idle();

    // Async reset while data bit 4 (a 0) is on the line.
    req_data[23:16] = 8'h00;
    req_valid = 4'b0100;
    @(negedge clk);
    check("mr_accept", 32'(req_ready), 32'b0100);
    @(posedge clk); #2 req_valid = '0;
    s = 0;
    for (int c = 0; c < 400 && s < 6; c++) begin
      @(posedge clk);
      if (baud_clk) s++;
    end
    check("mr_strobes", 32'(s), 32'd6);
    #1;
    check("mr_pre_serial", 32'(serial_out), 32'd0);
    check("mr_pre_busy",   32'(busy),       32'd1);
    check("mr_pre_grant",  32'(grant_id),   32'd2);
    #1 reset = 1'b1;
    #1;
    check("mr_serial", 32'(serial_out), 32'd1);
    check("mr_busy",   32'(busy),       32'd0);
    check("mr_grant",  32'(grant_id),   32'd0);
    check("mr_ready",  32'(req_ready),  32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    check("mr_next_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #2 req_valid = '0;
    wait_idle();

    // 0x07 from requester 1 (parity bit 1 when enabled).
    run_frame(1, 8'h07, bits, bs);
    check("x07_bits",        32'(bits), 32'(exp_07));
    check("x07_busy_strobe", 32'(bs),   32'(FL + 1));
    check("x07_grant",       32'(grant_id), 32'd1);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
